// File: rtl/request_encoder.sv
// request_encoder: debounces four request buttons, encodes presses into
// 3-bit request codes and keeps up to two pending requests in arrival order.
//
// Ports:
//   clk    - system clock, rising edge
//   rst_n  - asynchronous active-low reset
//   B      - raw asynchronous button levels, active-high
//   ACK    - one-cycle pulse, oldest request (F1) serviced
//   F1     - oldest pending request code (3'b000 = none)
//   F2     - second pending request code (3'b000 = none)
//   OVF    - one-cycle pulse, accepted press dropped because both slots full
//
// Build option: define DEBOUNCE_EN to compile the per-button debounce
// counters; without it the debounced level is the synchronized level.
module request_encoder #(
    parameter int DEB_CYCLES = 16,
    parameter int CNT_W      = 5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] B,
    input  logic       ACK,
    output logic [2:0] F1,
    output logic [2:0] F2,
    output logic       OVF
);

    typedef enum logic [1:0] {
        S_EMPTY,
        S_ONE,
        S_TWO
    } state_e;

    logic [3:0] sync1_q;
    logic [3:0] sync2_q;
    logic [3:0] lvl;
    logic [3:0] prev_q;
    logic [3:0] rise;
    logic [3:0] pend_q;
    logic [3:0] pend_d;
    logic [3:0] elig;
    logic [3:0] sel_oh;
    logic       sel_v;
    logic [2:0] sel_code;

    state_e     state_q;
    state_e     state_d;
    logic [2:0] f1_q;
    logic [2:0] f1_d;
    logic [2:0] f2_q;
    logic [2:0] f2_d;
    logic       ovf_q;
    logic       ovf_d;

    logic       pop;
    logic       dup;
    logic       cand;
    logic [2:0] f1_a;
    logic [2:0] f2_a;

    if (DEB_CYCLES < 2 || (2 ** CNT_W) <= DEB_CYCLES) begin : g_bad_params
        $error("request_encoder: DEB_CYCLES/CNT_W out of range");
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= B;
            sync2_q <= sync1_q;
        end
    end

`ifdef DEBOUNCE_EN
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

    logic [3:0]       deb_q;
    logic [3:0]       deb_d;
    logic [CNT_W-1:0] cnt_q [4];
    logic [CNT_W-1:0] cnt_d [4];

    // Counter runs only while the synchronized input disagrees with the
    // debounced level; any agreeing sample restarts the count.
    always_comb begin
        deb_d = deb_q;
        for (int i = 0; i < 4; i++) begin
            cnt_d[i] = '0;
            if (sync2_q[i] != deb_q[i]) begin
                if (cnt_q[i] == CNT_LAST) begin
                    deb_d[i] = ~deb_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            deb_q <= '0;
            for (int i = 0; i < 4; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            deb_q <= deb_d;
            for (int i = 0; i < 4; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign lvl = deb_q;
`else
    assign lvl = sync2_q;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_q <= '0;
        end else begin
            prev_q <= lvl;
        end
    end

    assign rise = lvl & ~prev_q;

    // A fresh rising edge is eligible in the same cycle it is seen, so
    // acceptance adds only one cycle after the debounced level rises.
    assign elig = pend_q | rise;

    always_comb begin
        sel_v    = 1'b1;
        sel_oh   = 4'b0000;
        sel_code = 3'b000;
        unique casez (elig)
            4'b???1: begin sel_oh = 4'b0001; sel_code = 3'b001; end
            4'b??10: begin sel_oh = 4'b0010; sel_code = 3'b011; end
            4'b?100: begin sel_oh = 4'b0100; sel_code = 3'b100; end
            4'b1000: begin sel_oh = 4'b1000; sel_code = 3'b110; end
            default: sel_v = 1'b0;
        endcase
    end

    // Queue contents as they stand after any same-cycle retire; the
    // duplicate filter compares against these.
    assign pop  = ACK && (state_q != S_EMPTY);
    assign f1_a = pop ? f2_q : f1_q;
    assign f2_a = pop ? 3'b000 : f2_q;
    assign dup  = sel_v && (sel_code == f1_a || sel_code == f2_a);
    assign cand = sel_v && !dup;

    always_comb begin
        state_d = state_q;
        f1_d    = f1_q;
        f2_d    = f2_q;
        ovf_d   = 1'b0;
        pend_d  = elig & ~sel_oh;
        unique case (state_q)
            S_EMPTY: begin
                if (cand) begin
                    state_d = S_ONE;
                    f1_d    = sel_code;
                end
            end
            S_ONE: begin
                if (ACK && cand) begin
                    f1_d = sel_code;
                end else if (ACK) begin
                    state_d = S_EMPTY;
                    f1_d    = 3'b000;
                end else if (cand) begin
                    state_d = S_TWO;
                    f2_d    = sel_code;
                end
            end
            S_TWO: begin
                if (ACK) begin
                    f1_d = f2_q;
                    if (cand) begin
                        f2_d = sel_code;
                    end else begin
                        state_d = S_ONE;
                        f2_d    = 3'b000;
                    end
                end else if (cand) begin
                    ovf_d = 1'b1;
                end
            end
            default: begin
                state_d = S_EMPTY;
                f1_d    = 3'b000;
                f2_d    = 3'b000;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_EMPTY;
            f1_q    <= 3'b000;
            f2_q    <= 3'b000;
            ovf_q   <= 1'b0;
            pend_q  <= '0;
        end else begin
            state_q <= state_d;
            f1_q    <= f1_d;
            f2_q    <= f2_d;
            ovf_q   <= ovf_d;
            pend_q  <= pend_d;
        end
    end

    assign F1  = f1_q;
    assign F2  = f2_q;
    assign OVF = ovf_q;

endmodule
